ddr_rd_checker: RTL

Read-data checker on the DDR4 test path. It sits directly downstream of the DDR read channel (`rdata_vld` / `rdata`) and in parallel with the read-request issuer. For each read burst it regenerates the address-derived pattern the write path stored, compares every returned beat, and reports error count, first-error details, completion and timeout. Results feed on-chip debug (ILA/VIO) for board bring-up.

---
 rtl/ddr_rd_checker.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ddr_rd_checker.sv
// DDR read-data checker: regenerates the {~addr, addr} pattern per beat,
// compares every returned beat and reports error/first-error/timeout results.
module ddr_rd_checker #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  chk_start,
  input  logic [ADDR_WIDTH-1:0] chk_addr,
  input  logic [LEN_WIDTH-1:0]  chk_len,
  input  logic                  rdata_vld,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  chk_busy,
  output logic                  chk_done,
  output logic                  chk_pass,
  output logic [LEN_WIDTH-1:0]  err_cnt,
  output logic [LEN_WIDTH-1:0]  first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_data,
  output logic                  timeout_flag,
  output logic                  stray_flag
);

  localparam int unsigned BEAT_BYTES = DATA_WIDTH / 8;
  localparam int unsigned TW         = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LEN_WIDTH-1:0]    rem_q;
  logic [LEN_WIDTH-1:0]    idx_q;
  logic [TW-1:0]           tmo_q;
  logic                    done_q;
  logic                    pass_q;
  logic [LEN_WIDTH-1:0]    err_cnt_q;
  logic [LEN_WIDTH-1:0]    first_idx_q;
  logic [DATA_WIDTH-1:0]   first_data_q;
  logic                    timeout_q;
  logic                    stray_q;

  logic [DATA_WIDTH-1:0]   expected;
  logic                    mismatch;
  logic [LEN_WIDTH-1:0]    err_cnt_d;
  logic                    last_beat;

  always_comb begin
    expected  = {~addr_q, addr_q};
    mismatch  = (rdata != expected);
    err_cnt_d = err_cnt_q;
    if (mismatch && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + LEN_WIDTH'(1);
    last_beat = (rem_q == LEN_WIDTH'(1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      idx_q        <= '0;
      tmo_q        <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      timeout_q    <= 1'b0;
      stray_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rdata_vld)
            stray_q <= 1'b1;
          if (chk_start) begin
            err_cnt_q    <= '0;
            first_idx_q  <= '0;
            first_data_q <= '0;
            timeout_q    <= 1'b0;
            pass_q       <= 1'b0;
            if (chk_len == '0) begin
              done_q <= 1'b1;
              pass_q <= 1'b1;
            end else begin
              state_q <= RUN;
              addr_q  <= chk_addr;
              rem_q   <= chk_len;
              idx_q   <= '0;
              tmo_q   <= '0;
            end
          end
        end
        RUN: begin
          if (rdata_vld) begin
            addr_q    <= addr_q + ADDR_WIDTH'(BEAT_BYTES);
            rem_q     <= rem_q - LEN_WIDTH'(1);
            idx_q     <= idx_q + LEN_WIDTH'(1);
            tmo_q     <= '0;
            err_cnt_q <= err_cnt_d;
            // err_cnt never returns to zero within a burst, so zero marks "no mismatch yet"
            if (mismatch && (err_cnt_q == '0)) begin
              first_idx_q  <= idx_q;
              first_data_q <= rdata;
            end
            if (last_beat) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == '0);
            end
          end else if (tmo_q == TW'(TIMEOUT)) begin
            state_q   <= IDLE;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign chk_busy       = (state_q == RUN);
  assign chk_done       = done_q;
  assign chk_pass       = pass_q;
  assign err_cnt        = err_cnt_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_data = first_data_q;
  assign timeout_flag   = timeout_q;
  assign stray_flag     = stray_q;

endmodule
